// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multiport register file
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;
    localparam int ZERO_REG      = 0;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one registered read port (x0 mask, range check, optional bypass via REGFILE_BYPASS_EN)
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int NREGS = DEFAULT_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] row,
    input  logic            wr_fire,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rd_data
);

    localparam logic [AW:0] LIMIT = (AW+1)'(NREGS);

    logic [XLEN-1:0] rd_data_q;
    logic [XLEN-1:0] rd_data_d;
    logic            addr_ok;

    assign addr_ok = (rd_addr != AW'(ZERO_REG)) && ({1'b0, rd_addr} < LIMIT);

`ifndef REGFILE_BYPASS_EN
    // Write-port signals only feed the bypass mux; keep them referenced.
    logic unused_wr;
    assign unused_wr = ^{wr_fire, wr_addr, wr_data};
`endif

    // Select the value to capture: zero for x0/out-of-range/clear, else the row or the bypassed write.
    always_comb begin
        rd_data_d = '0;
        if (rd_en && addr_ok) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_fire && (wr_addr == rd_addr)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = row;
            end
`else
            rd_data_d = row;
`endif
        end
    end

    // Registered output; reset forces zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - NRD-read/1-write register file with x0, clear sequencer, optional REGFILE_BYPASS_EN bypass
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int XLEN  = DEFAULT_XLEN,
    parameter  int NREGS = DEFAULT_NREGS,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NRD*AW-1:0]   RdAddr,
    output logic [NRD*XLEN-1:0] RdData,
    input  logic                WrEn,
    input  logic [AW-1:0]       WrAddr,
    input  logic [XLEN-1:0]     WrData,
    output logic                Busy
);

    localparam logic [AW:0]   LIMIT = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

    state_e          state_q;
    state_e          state_d;
    logic [AW-1:0]   ptr_q;
    logic [AW-1:0]   ptr_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic            wr_fire;
    logic            rd_en;

    // State register and clear pointer; reset restarts the clear from entry 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: walk the pointer through every entry, leave CLEAR on the last one.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            if (ptr_q == LAST) begin
                state_d = READY;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end
    end

    // Outputs: choose the storage write source (clear zeroing or the architectural write port).
    always_comb begin
        Busy      = (state_q == CLEAR);
        rd_en     = 1'b0;
        wr_fire   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (!RST) begin
            if (state_q == CLEAR) begin
                mem_we = 1'b1;
            end else begin
                rd_en     = 1'b1;
                wr_fire   = WrEn && (WrAddr != AW'(ZERO_REG)) && ({1'b0, WrAddr} < LIMIT);
                mem_we    = wr_fire;
                mem_waddr = WrAddr;
                mem_wdata = WrData;
            end
        end
    end

    // Storage array: single write port, no reset (the sequencer zeroes it).
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = RdAddr[i*AW +: AW];

        regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_port (
            .clk     (CLK),
            .rst     (RST),
            .rd_en   (rd_en),
            .rd_addr (addr),
            .row     (regs_q[addr]),
            .wr_fire (wr_fire),
            .wr_addr (WrAddr),
            .wr_data (WrData),
            .rd_data (data)
        );

        assign RdData[i*XLEN +: XLEN] = data;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - scoreboard bench for regfile_multiport (32-entry and 20-entry instances)
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int NR_A = 32;
    localparam int NR_B = 20;

    logic        CLK;
    logic        RST;
    logic [9:0]  RdAddr;
    logic        WrEn;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic        busy_a;
    logic        busy_b;

    regfile_multiport #(.XLEN(32), .NREGS(NR_A), .NRD(2)) dut_a (
        .CLK(CLK), .RST(RST), .RdAddr(RdAddr), .RdData(rd_a),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Busy(busy_a)
    );

    regfile_multiport #(.XLEN(32), .NREGS(NR_B), .NRD(2)) dut_b (
        .CLK(CLK), .RST(RST), .RdAddr(RdAddr), .RdData(rd_b),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Busy(busy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0][31:0] rd;    // index d*2+p
        logic [1:0]       busy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;

    // Reference model: contents per instance plus a countdown of clear cycles left.
    logic [31:0] mregs [2][32];
    int          clear_left [2];
    int          nregs [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, predict the post-edge outputs, queue the prediction.
    task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t e;
        int   ra [2];
        ra[0] = int'(ra0);
        ra[1] = int'(ra1);
        RST    = rst;
        WrEn   = we;
        WrAddr = wa;
        WrData = wd;
        RdAddr = {ra1, ra0};
        e = '0;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                clear_left[d] = nregs[d];
                for (int r = 0; r < 32; r++) mregs[d][r] = '0;
            end else if (clear_left[d] > 0) begin
                clear_left[d] = clear_left[d] - 1;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (ra[p] == 0 || ra[p] >= nregs[d])
                        e.rd[d*2+p] = '0;
                    else if (BYP && we && int'(wa) == ra[p])
                        e.rd[d*2+p] = wd;
                    else
                        e.rd[d*2+p] = mregs[d][ra[p]];
                end
                if (we && wa != 0 && int'(wa) < nregs[d]) mregs[d][wa] = wd;
            end
            e.busy[d] = (clear_left[d] > 0);
        end
        @(posedge CLK);
        q.push_back(e);
        #1;
    endtask

    // Monitor: every falling edge, compare all queued predictions against the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_pop++;
                check($sformatf("busy_a@%0d", n_pop), {31'd0, busy_a}, {31'd0, e.busy[0]});
                check($sformatf("busy_b@%0d", n_pop), {31'd0, busy_b}, {31'd0, e.busy[1]});
                check($sformatf("a_rd0@%0d", n_pop), rd_a[31:0],  e.rd[0]);
                check($sformatf("a_rd1@%0d", n_pop), rd_a[63:32], e.rd[1]);
                check($sformatf("b_rd0@%0d", n_pop), rd_b[31:0],  e.rd[2]);
                check($sformatf("b_rd1@%0d", n_pop), rd_b[63:32], e.rd[3]);
            end
        end
    end

    initial begin
        logic        r;
        logic        w;
        logic [4:0]  wa;
        logic [4:0]  a0;
        logic [4:0]  a1;
        nregs[0] = NR_A;
        nregs[1] = NR_B;
        clear_left[0] = 0;
        clear_left[1] = 0;
        RST = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0; RdAddr = '0;

        // Reset for two cycles, then clear while trying to write x4.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 34; i++) cycle(0, 1, 5'd4, 32'h55, 5'd4, 5'(i));

        // Every entry on both ports.
        for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 5'(i), 5'(31 - i));

        // Write then read on both ports.
        cycle(0, 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        cycle(0, 0, 0, 0, 5'd5, 5'd5);
        cycle(0, 0, 0, 0, 5'd5, 5'd5);

        // x0 protection.
        cycle(0, 1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        cycle(0, 0, 0, 0, 5'd0, 5'd0);

        // Same-cycle collision on x7.
        cycle(0, 1, 5'd7, 32'h11, 5'd0, 5'd0);
        cycle(0, 1, 5'd7, 32'h22, 5'd7, 5'd7);
        cycle(0, 0, 0, 0, 5'd7, 5'd7);

        // Reset during READY loses x3.
        cycle(0, 1, 5'd3, 32'hAA, 5'd0, 5'd0);
        cycle(0, 0, 0, 0, 5'd3, 5'd3);
        cycle(1, 0, 0, 0, 5'd3, 5'd3);
        for (int i = 0; i < 33; i++) cycle(0, 0, 0, 0, 5'd3, 5'd5);

        // Reset when the clear pointer reaches 10, full clear again.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 5'd9, 32'h99, 5'd9, 5'd1);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 34; i++) cycle(0, 0, 0, 0, 5'd9, 5'd1);

        // Randomised traffic including out-of-range addresses on the 20-entry instance.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 149) == 0);
            w  = ($urandom_range(0, 1) == 1);
            wa = 5'($urandom_range(0, 31));
            a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            cycle(r, w, wa, $urandom, a0, a1);
        end

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the single-cycle core's register file: XLEN-wide, NREGS-deep, with NRD synchronous read ports and one write port. Adds a hardwired-zero x0, optional write-to-read bypass, and a hardware clear sequencer that zeroes every entry after reset. Sits between decode (read addresses) and writeback (write port). It serves the single-cycle core and the planned pipelined core.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (≥2)
- NRD, 2, number of read ports (≥1)
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- CLK  input  1  single clock, all state on posedge
- RST  input  1  synchronous, active-high reset
- RdAddr  input  NRD*AW  packed read addresses; port i at [i*AW +: AW]
- RdData  output  NRD*XLEN  packed registered read data; port i at [i*XLEN +: XLEN]
- WrEn  input  1  write enable
- WrAddr  input  AW  write address
- WrData  input  XLEN  write data
- Busy  output  1  high while the clear sequencer runs; core must stall

## Operation
- State machine: CLEAR, READY.
- RST=1 at a posedge: the next state is CLEAR, the clear pointer is 0, all RdData are 0, and Busy is 1.
- CLEAR, RST=0: each cycle writes 0 to entry[ptr] and increments ptr. The transition to READY happens on the cycle that clears entry NREGS-1.
- In CLEAR, WrEn is ignored and RdData stays 0.
- READY: every posedge, RdData[i] <= entry[RdAddr[i]] for every port i. If WrEn=1, WrAddr≠0 and WrAddr<NREGS, then entry[WrAddr] <= WrData.
- x0: writes to address 0 are dropped. Reads of address 0 always return 0, independent of bypass.
- Out-of-range addresses (≥NREGS, only possible when NREGS is not a power of two): reads return 0 and writes are dropped.
- Multiple read ports may use the same address. Each port receives the same value.
- RST asserted mid-CLEAR or mid-READY: the sequence restarts from ptr=0 and register contents are cleared again. There is no partial retention.

## Timing
- Read latency is 1 cycle: an address presented before posedge N has its data valid after posedge N.
- Write latency is 1 cycle: data is stored at posedge N and visible to a read address presented before posedge N+1.
- Same-cycle read and write to the same non-zero address is governed by Configuration.
- Clear duration: Busy is 1 for the RST cycles plus NREGS cycles after the first cycle with RST=0. Busy falls after the posedge that clears entry NREGS-1.
- Reset values: RdData=0, Busy=1, state=CLEAR, ptr=0.

## Configuration
- REGFILE_BYPASS_EN defined: when WrEn=1 and WrAddr==RdAddr[i]≠0 in the same READY cycle, RdData[i] <= WrData (new value, write-through).
- REGFILE_BYPASS_EN undefined: RdData[i] <= old stored value (read-before-write), which matches the existing core's behaviour.
- The macro never affects x0, out-of-range addresses or CLEAR behaviour.

## Structure
- Shared package regfile_pkg:
  - state enum (CLEAR, READY)
  - default XLEN/NREGS constants
  - ZERO_REG address constant (0)
- One sub-module, regfile_read_port: one instance per port via generate.
  - Inputs: address, storage row, write-port signals.
  - Performs x0 masking, range check and optional bypass mux.
  - Outputs the registered data.
- The storage array, clear sequencer and write logic live in the top-level module.

## Test plan
- Reset/clear: NREGS=32, RST high for 2 cycles then low → Busy=1 for exactly 32 cycles after RST falls. Afterwards all 32 entries read 0 on both ports.
- Write then read: write 0xDEADBEEF to x5 at cycle N, read x5 at N+1 → RdData[0]=0xDEADBEEF at N+2. Port 1 reading x5 simultaneously shows the same value.
- x0 protection: write 0x12345678 to x0, then read x0 on all ports → all return 0x00000000.
- Same-cycle collision: x7 holds 0x11, write 0x22 to x7 while port 0 reads x7 → RdData[0]=0x22 with REGFILE_BYPASS_EN, 0x11 without. The next read returns 0x22 in both builds.
- Reset mid-clear and mid-run: x3 holds 0xAA, assert RST for 1 cycle during READY → x3 reads 0 after the clear completes. RST asserted at ptr=10 in CLEAR → Busy lasts a full 32 cycles again.
- Writes during CLEAR: WrEn=1, x4 ← 0x55 during the clear → x4 reads 0 once Busy falls.
